mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage consumer of the execute-stage results: the address/ALU result, the store data, the branch target and the zero flag.
- Runs LDUR/STUR accesses against a multi-cycle data memory over a req/ack handshake.
- Stalls the pipeline until each access completes, and resolves the branch decision (PCSrc_M).
- Sits between the EX/MEM pipeline register and the MEM/WB register of the 64-bit LEGv8 pipeline.

Parameters:
N, 64, datapath/address width in bits
TIMEOUT, 255, max cycles to wait for dm_ack before aborting (must be >= 1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
valid_M  in  1  EX/MEM register holds a live instruction
MemRead_M  in  1  load request
MemWrite_M  in  1  store request
Branch_M  in  1  conditional branch (CBZ)
zero_M  in  1  ALU zero flag from execute
aluResult_M  in  N  byte address / ALU result
writeData_M  in  N  store data
PCBranch_M  in  N  branch target
dm_req  out  1  memory request
dm_we  out  1  1 = write, 0 = read
dm_addr  out  N  memory address
dm_wdata  out  N  write data
dm_ack  in  1  memory completed request (single-cycle pulse)
dm_rdata  in  N  read data, valid with dm_ack
readData_M  out  N  load result to MEM/WB
stall_M  out  1  freeze IF..EX/MEM registers
err_M  out  1  access fault (misaligned or timeout), valid in DONE
PCSrc_M  out  1  take branch
PCBranch_out_M  out  N  branch target passthrough

Behaviour:
- Reset (reset=0, async): state=IDLE; dm_req, dm_we, err_M = 0; dm_addr, dm_wdata, readData_M, timeout counter = 0.
- PCSrc_M = Branch_M & zero_M & valid_M, combinational. PCBranch_out_M = PCBranch_M. Neither depends on FSM state.
- op = valid_M & (MemRead_M | MemWrite_M).
- MemWrite_M has priority: when both MemRead_M and MemWrite_M are set, a write is performed.
- Misaligned: aluResult_M[2:0] != 0.
- stall_M (combinational) = (IDLE & op) | ACCESS. It is 0 in DONE.
- IDLE:
  - op & aligned: register dm_addr=aluResult_M, dm_wdata=writeData_M, dm_we=MemWrite_M; set dm_req=1; clear counter; go to ACCESS.
  - op & misaligned: no request; set err_M=1; go to DONE.
  - no op: stay in IDLE.
- ACCESS:
  - dm_req, dm_we, dm_addr and dm_wdata are held stable until dm_ack.
  - Counter increments each cycle.
  - dm_ack=1: dm_req=0; readData_M=dm_rdata if read (unchanged on write); err_M=0; go to DONE.
  - Counter reaches TIMEOUT-1 without ack: dm_req=0; readData_M=0; err_M=1; go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE: exactly one cycle. Pipeline advances (stall_M=0), then go to IDLE and clear err_M.
- Because the pipeline advances during DONE, the next IDLE cycle always sees a new instruction, so no access is repeated.
- Latency: load with ack k cycles after dm_req rises → readData_M valid in DONE. Total stall = k+1 cycles (one IDLE + k ACCESS).
- dm_ack outside ACCESS is ignored.
- Reset mid-ACCESS: dm_req drops immediately; the access is abandoned and not retried.
- readData_M holds its last value outside DONE.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
  - localparam ALIGN_BITS = 3.
- One natural sub-module: mem_timeout_ctr (loadable up-counter with terminal-count flag, width $clog2(TIMEOUT+1)).
- Branch resolution stays inline.

Test Plan:
- Aligned load: addr=0x40, MemRead=1, ack after 3 cycles with rdata=0xDEAD_BEEF → dm_req high 3 cycles, dm_we=0, stall_M high 4 cycles, readData_M=0xDEAD_BEEF in DONE, err_M=0.
- Aligned store: addr=0x88, wdata=0x1234, ack after 1 cycle → dm_we=1, dm_addr=0x88, dm_wdata=0x1234 stable until ack, stall 2 cycles, readData_M unchanged.
- Misaligned load: addr=0x43 → dm_req never rises, stall_M 1 cycle, err_M=1 in DONE.
- Timeout with TIMEOUT=4, no ack → dm_req high exactly 4 cycles, then DONE with err_M=1, readData_M=0. Repeat with ack on cycle 4 → ack wins, err_M=0.
- Branch: Branch=1, zero=1, PCBranch=0x100, no mem op → PCSrc_M=1, PCBranch_out_M=0x100, stall_M=0. With zero=0 → PCSrc_M=0.
- Reset asserted mid-ACCESS → dm_req=0 and state=IDLE immediately. After release, a new load proceeds normally, and a late dm_ack is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================
// mem_pkg : shared types for the memory-stage access unit
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

package mem_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam int ALIGN_BITS = 3;
endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================
// mem_timeout_ctr : clearable up-counter with terminal-count flag
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module mem_timeout_ctr #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 254
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en)
      count <= count + WIDTH'(1);
  end

  assign tc = (count == TC_VAL);
endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================
// mem_access_unit : LEGv8 MEM stage - LDUR/STUR over req/ack, CBZ resolve
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_M,
  input  logic         MemRead_M,
  input  logic         MemWrite_M,
  input  logic         Branch_M,
  input  logic         zero_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  input  logic [N-1:0] PCBranch_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic [N-1:0] readData_M,
  output logic         stall_M,
  output logic         err_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_out_M
);
  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_t   state, state_nx;
  logic         op, misaligned, timed_out;
  logic         req_nx, we_nx, err_nx;
  logic [N-1:0] addr_nx, wdata_nx, rdata_nx;
  logic         ctr_clear, ctr_en;

  assign op             = valid_M & (MemRead_M | MemWrite_M);
  assign misaligned     = |aluResult_M[ALIGN_BITS-1:0];
  assign PCSrc_M        = Branch_M & zero_M & valid_M;
  assign PCBranch_out_M = PCBranch_M;
  assign stall_M        = ((state == IDLE) && op) || (state == ACCESS);

  mem_timeout_ctr #(
    .WIDTH    (CW),
    .TERMINAL (TIMEOUT - 1)
  ) u_timeout_ctr (
    .clk   (clk),
    .reset (reset),
    .clear (ctr_clear),
    .en    (ctr_en),
    .tc    (timed_out)
  );

  always_comb begin
    state_nx  = state;
    req_nx    = dm_req;
    we_nx     = dm_we;
    err_nx    = err_M;
    addr_nx   = dm_addr;
    wdata_nx  = dm_wdata;
    rdata_nx  = readData_M;
    ctr_clear = 1'b0;
    ctr_en    = (state == ACCESS);
    case (state)
      IDLE: begin
        if (op) begin
          if (misaligned) begin
            err_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            // Write wins when both strobes are set
            addr_nx   = aluResult_M;
            wdata_nx  = writeData_M;
            we_nx     = MemWrite_M;
            req_nx    = 1'b1;
            ctr_clear = 1'b1;
            state_nx  = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (dm_ack) begin
          req_nx = 1'b0;
          if (!dm_we)
            rdata_nx = dm_rdata;
          err_nx   = 1'b0;
          state_nx = DONE;
        end else if (timed_out) begin
          req_nx   = 1'b0;
          rdata_nx = '0;
          err_nx   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        err_nx   = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      err_M      <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      readData_M <= '0;
    end else begin
      state      <= state_nx;
      dm_req     <= req_nx;
      dm_we      <= we_nx;
      err_M      <= err_nx;
      dm_addr    <= addr_nx;
      dm_wdata   <= wdata_nx;
      readData_M <= rdata_nx;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================
// tb_mem_access_unit : directed self-checking bench for mem_access_unit
// Rev 1.0 : initial release
// ============================================================
`default_nettype none

module tb_mem_access_unit;
  localparam int N       = 64;
  localparam int TIMEOUT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_M, MemRead_M, MemWrite_M, Branch_M, zero_M;
  logic [N-1:0] aluResult_M, writeData_M, PCBranch_M;
  logic         dm_req, dm_we, dm_ack;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata, readData_M, PCBranch_out_M;
  logic         stall_M, err_M, PCSrc_M;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_M        (valid_M),
    .MemRead_M      (MemRead_M),
    .MemWrite_M     (MemWrite_M),
    .Branch_M       (Branch_M),
    .zero_M         (zero_M),
    .aluResult_M    (aluResult_M),
    .writeData_M    (writeData_M),
    .PCBranch_M     (PCBranch_M),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_ack         (dm_ack),
    .dm_rdata       (dm_rdata),
    .readData_M     (readData_M),
    .stall_M        (stall_M),
    .err_M          (err_M),
    .PCSrc_M        (PCSrc_M),
    .PCBranch_out_M (PCBranch_out_M)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one memory op, acks on ACCESS cycle ack_at (0 = never) and
  // returns once stall drops, i.e. with the DUT sitting in DONE.
  task automatic access(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input int ack_at, input logic [63:0] rdv,
                        output int reqs, output int stalls, output logic stable);
    valid_M = 1'b1; MemRead_M = rd; MemWrite_M = wr;
    aluResult_M = addr; writeData_M = wd;
    #1;
    reqs = 0; stalls = stall_M ? 1 : 0; stable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      dm_ack = 1'b0;
      #1;
      if (!stall_M) break;
      stalls++;
      if (dm_req) begin
        reqs++;
        if (dm_addr !== addr || dm_wdata !== wd || dm_we !== wr) stable = 1'b0;
      end
      if (c == ack_at) begin
        dm_ack = 1'b1; dm_rdata = rdv;
      end
    end
  endtask

  task automatic retire(input string tag);
    valid_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
    @(posedge clk); #2;
    check({tag, "_err_clear"}, {63'd0, err_M}, 64'd0);
  endtask

  int   reqs, stalls;
  logic stable;

  initial begin
    reset = 1'b0;
    valid_M = 0; MemRead_M = 0; MemWrite_M = 0; Branch_M = 0; zero_M = 0;
    aluResult_M = '0; writeData_M = '0; PCBranch_M = '0;
    dm_ack = 0; dm_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req",   {63'd0, dm_req}, 64'd0);
    check("rst_we",    {63'd0, dm_we},  64'd0);
    check("rst_err",   {63'd0, err_M},  64'd0);
    check("rst_stall", {63'd0, stall_M}, 64'd0);
    check("rst_addr",  dm_addr,    64'd0);
    check("rst_wdata", dm_wdata,   64'd0);
    check("rst_rdata", readData_M, 64'd0);
    @(negedge clk); reset = 1'b1;

    // Aligned load, ack on 3rd request cycle
    @(posedge clk); #2;
    access(1'b1, 1'b0, 64'h40, 64'h0, 3, 64'hDEAD_BEEF, reqs, stalls, stable);
    check("ld_reqs",   64'(reqs),   64'd3);
    check("ld_stall",  64'(stalls), 64'd4);
    check("ld_stable", {63'd0, stable}, 64'd1);
    check("ld_rdata",  readData_M, 64'hDEAD_BEEF);
    check("ld_err",    {63'd0, err_M},  64'd0);
    check("ld_done_req", {63'd0, dm_req}, 64'd0);
    retire("ld");

    // Aligned store, ack on 1st request cycle
    access(1'b0, 1'b1, 64'h88, 64'h1234, 1, 64'hFFFF, reqs, stalls, stable);
    check("st_reqs",   64'(reqs),   64'd1);
    check("st_stall",  64'(stalls), 64'd2);
    check("st_stable", {63'd0, stable}, 64'd1);
    check("st_rdata",  readData_M, 64'hDEAD_BEEF);
    check("st_err",    {63'd0, err_M}, 64'd0);
    retire("st");

    // Both strobes: write takes priority
    access(1'b1, 1'b1, 64'h90, 64'h77, 1, 64'h1, reqs, stalls, stable);
    check("rw_stable", {63'd0, stable}, 64'd1);
    check("rw_rdata",  readData_M, 64'hDEAD_BEEF);
    retire("rw");

    // Misaligned load
    access(1'b1, 1'b0, 64'h43, 64'h0, 1, 64'h9, reqs, stalls, stable);
    check("mis_reqs",  64'(reqs),   64'd0);
    check("mis_stall", 64'(stalls), 64'd1);
    check("mis_err",   {63'd0, err_M}, 64'd1);
    check("mis_rdata", readData_M, 64'hDEAD_BEEF);
    retire("mis");

    // Timeout, no ack
    access(1'b1, 1'b0, 64'h100, 64'h0, 0, 64'h0, reqs, stalls, stable);
    check("to_reqs",  64'(reqs),   64'd4);
    check("to_stall", 64'(stalls), 64'd5);
    check("to_err",   {63'd0, err_M}, 64'd1);
    check("to_rdata", readData_M, 64'd0);
    retire("to");

    // Ack on the timeout cycle: ack wins
    access(1'b1, 1'b0, 64'h108, 64'h0, 4, 64'hCAFE, reqs, stalls, stable);
    check("tw_reqs",  64'(reqs), 64'd4);
    check("tw_err",   {63'd0, err_M}, 64'd0);
    check("tw_rdata", readData_M, 64'hCAFE);
    retire("tw");

    // Branch resolution
    valid_M = 1'b1; Branch_M = 1'b1; zero_M = 1'b1; PCBranch_M = 64'h100; #1;
    check("br_taken",  {63'd0, PCSrc_M}, 64'd1);
    check("br_target", PCBranch_out_M, 64'h100);
    check("br_stall",  {63'd0, stall_M}, 64'd0);
    zero_M = 1'b0; #1;
    check("br_nz", {63'd0, PCSrc_M}, 64'd0);
    zero_M = 1'b1; valid_M = 1'b0; #1;
    check("br_inv", {63'd0, PCSrc_M}, 64'd0);
    Branch_M = 1'b0; zero_M = 1'b0;

    // Reset in the middle of an access
    valid_M = 1'b1; MemRead_M = 1'b1; aluResult_M = 64'h200;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("mr_req_before", {63'd0, dm_req}, 64'd1);
    reset = 1'b0; #1;
    check("mr_req",   {63'd0, dm_req}, 64'd0);
    check("mr_rdata", readData_M, 64'd0);
    valid_M = 1'b0; MemRead_M = 1'b0; #1;
    check("mr_stall", {63'd0, stall_M}, 64'd0);
    @(negedge clk); reset = 1'b1;
    dm_ack = 1'b1; dm_rdata = 64'hBAD;
    @(posedge clk); #2;
    dm_ack = 1'b0;
    check("late_ack_req",   {63'd0, dm_req}, 64'd0);
    check("late_ack_stall", {63'd0, stall_M}, 64'd0);
    check("late_ack_rdata", readData_M, 64'd0);
    access(1'b1, 1'b0, 64'h208, 64'h0, 2, 64'h5555, reqs, stalls, stable);
    check("post_reqs",  64'(reqs),   64'd2);
    check("post_stall", 64'(stalls), 64'd3);
    check("post_rdata", readData_M, 64'h5555);
    retire("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
